// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory byte loader.
// FSM state encodings and word/byte sizing helpers.
package im_loader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_RAM_DEPTH  = 64;

    localparam int BYTES = DEF_DATA_WIDTH / 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_COLLECT = 3'd1;
    localparam state_t S_SETUP   = 3'd2;
    localparam state_t S_WRITE   = 3'd3;
    localparam state_t S_HOLD    = 3'd4;
    localparam state_t S_DONE    = 3'd5;

    function automatic int word_bytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/im_word_packer.sv
// Little-endian byte-to-word assembler for the loader.
// Emits a one-cycle word_ready when the last byte of a word lands.
module im_word_packer
    import im_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  take,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_ready
);

    localparam int NB = word_bytes(DATA_WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] next_sr;

    generate
        if (DATA_WIDTH == 8) begin : g_single
            assign next_sr = byte_in;
        end else begin : g_shift
            assign next_sr = {byte_in, sr[DATA_WIDTH-1:8]};
        end
    endgenerate

    assign word_ready = take && (cnt == LAST);

    // Shift bytes in from the top; the word register only moves on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sr   <= '0;
            word <= '0;
        end else if (clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (take) begin
            sr <= next_sr;
            if (word_ready) begin
                cnt  <= '0;
                word <= next_sr;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// Streams bytes into the instruction memory write port.
// Each word gets a setup, a one-cycle write strobe, and a hold cycle.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] address_0,
    output logic [DATA_WIDTH-1:0] data_0,
    output logic                  cs_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  take;
    logic                  launch;
    logic                  word_ready;

    assign byte_ready = (state == S_COLLECT);
    assign cs_0       = (state == S_SETUP) || (state == S_WRITE) ||
                        (state == S_HOLD);
    assign we_0       = (state == S_WRITE);
    assign oe_0       = 1'b0;
    assign busy       = byte_ready || cs_0;
    assign done       = (state == S_DONE);

    assign take   = byte_valid && byte_ready;
    assign launch = start && ((state == S_IDLE) || (state == S_DONE));

    im_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch),
        .take       (take),
        .byte_in    (byte_in),
        .word       (data_0),
        .word_ready (word_ready)
    );

    // Load sequencer: collect a word, then setup/write/hold it to memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            len           <= '0;
            addr          <= '0;
            address_0     <= '0;
            words_written <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        len           <= (load_len == '0) ? FULL
                                         : {1'b0, load_len};
                        addr          <= '0;
                        words_written <= '0;
                        state         <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (word_ready) begin
                        address_0 <= addr;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: state <= S_WRITE;
                S_WRITE: state <= S_HOLD;
                S_HOLD: begin
                    words_written <= words_written + 1'b1;
                    addr          <= addr + 1'b1;
                    if (words_written + 1'b1 == len) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader with a behavioural 64x32 memory.
// Checks written contents, strobe shape, handshake and reset behaviour.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  load_len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [5:0]  address_0;
    logic [31:0] data_0;
    logic        cs_0;
    logic        we_0;
    logic        oe_0;
    logic        busy;
    logic        done;
    logic [6:0]  words_written;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64];
    int          we_cycles = 0;
    int          zero_writes = 0;
    int          stab_err = 0;
    int          rdy_cycles = 0;
    logic [5:0]  last_waddr = '0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;
    logic        prev_we = 1'b0;

    im_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_len      (load_len),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .address_0     (address_0),
        .data_0        (data_0),
        .cs_0          (cs_0),
        .we_0          (we_0),
        .oe_0          (oe_0),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Memory model plus strobe-stability monitor.
    always @(posedge clk) begin
        if (byte_ready) rdy_cycles = rdy_cycles + 1;
        if (cs_0 && we_0) begin
            mem[address_0] = data_0;
            we_cycles = we_cycles + 1;
            last_waddr = address_0;
            if (address_0 == 6'd0) zero_writes = zero_writes + 1;
            if (address_0 !== prev_a || data_0 !== prev_d)
                stab_err = stab_err + 1;
        end
        if (prev_we && !(cs_0 && !we_0 &&
            address_0 === prev_a && data_0 === prev_d))
            stab_err = stab_err + 1;
        prev_a  = address_0;
        prev_d  = data_0;
        prev_we = we_0;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [5:0] len);
        @(negedge clk);
        load_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_we(input logic [5:0] a);
        int n;
        n = 0;
        while (!(we_0 && address_0 == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("we_seen", we_0, 1);
    endtask

    initial begin
        int base_we;
        int base_zero;
        int base_rdy;

        #12;
        check("rst_ready", byte_ready, 0);
        check("rst_cs", cs_0, 0);
        check("rst_we", we_0, 0);
        check("rst_oe", oe_0, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", address_0, 0);
        check("rst_data", data_0, 0);
        check("rst_ww", words_written, 0);
        @(negedge clk);
        rst = 1'b0;

        // Two words, valid held high.
        base_we = we_cycles;
        do_start(6'd2);
        check("t1_ready", byte_ready, 1);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)), 0);
        byte_valid = 1'b0;
        wait_done("t1_done");
        check("t1_mem0", mem[0], 32'h44332211);
        check("t1_mem1", mem[1], 32'h88776655);
        check("t1_we", we_cycles - base_we, 2);
        check("t1_ww", words_written, 2);
        check("t1_busy_done", busy, 0);

        // Full memory, incrementing bytes.
        base_we = we_cycles;
        base_zero = zero_writes;
        do_start(6'd0);
        for (int i = 0; i < 256; i++) send(8'(i), 0);
        byte_valid = 1'b0;
        wait_done("t2_done");
        check("t2_mem0", mem[0], 32'h03020100);
        check("t2_mem32", mem[32], 32'h83828180);
        check("t2_mem63", mem[63], 32'hFFFEFDFC);
        check("t2_we", we_cycles - base_we, 64);
        check("t2_zero", zero_writes - base_zero, 1);
        check("t2_last", last_waddr, 63);
        check("t2_ww", words_written, 64);
        check("t2_addr", address_0, 63);

        // Valid toggling every cycle, one word.
        base_we = we_cycles;
        do_start(6'd1);
        base_rdy = rdy_cycles;
        send(8'hA0, 1);
        send(8'hB1, 1);
        send(8'hC2, 1);
        send(8'hD3, 1);
        byte_valid = 1'b0;
        wait_done("t3_done");
        check("t3_rdy", rdy_cycles - base_rdy, 8);
        check("t3_mem0", mem[0], 32'hD3C2B1A0);
        check("t3_we", we_cycles - base_we, 1);

        // Start during WRITE is ignored.
        base_we = we_cycles;
        do_start(6'd2);
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 0);
                byte_valid = 1'b0;
            end
            begin
                wait_we(6'd0);
                load_len = 6'd5;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_done("t4_done");
        check("t4_ww", words_written, 2);
        check("t4_mem0", mem[0], 32'h24232221);
        check("t4_mem1", mem[1], 32'h28272625);
        check("t4_we", we_cycles - base_we, 2);
        check("t4_last", last_waddr, 1);

        // Asynchronous reset in the middle of word 1's strobe.
        do_start(6'd2);
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(8'h31 + i), 0);
                byte_valid = 1'b0;
            end
            begin
                wait_we(6'd1);
                #1;
                rst = 1'b1;
                #1;
                check("t5_we", we_0, 0);
                check("t5_cs", cs_0, 0);
                check("t5_busy", busy, 0);
                check("t5_ww", words_written, 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        base_we = we_cycles;
        do_start(6'd1);
        send(8'hA1, 0);
        send(8'hB2, 0);
        send(8'hC3, 0);
        send(8'hD4, 0);
        byte_valid = 1'b0;
        wait_done("t5_done");
        check("t5_mem0", mem[0], 32'hD4C3B2A1);
        check("t5_last", last_waddr, 0);
        check("t5_wecnt", we_cycles - base_we, 1);

        // Restart from DONE.
        check("t6_ww_pre", words_written, 1);
        do_start(6'd1);
        check("t6_ww_clr", words_written, 0);
        check("t6_done_lo", done, 0);
        send(8'h5A, 0);
        send(8'h6B, 0);
        send(8'h7C, 0);
        send(8'h8D, 0);
        byte_valid = 1'b0;
        wait_done("t6_done");
        check("t6_ww", words_written, 1);
        check("t6_mem0", mem[0], 32'h8D7C6B5A);

        // Bytes offered in DONE are not consumed.
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        repeat (3) @(negedge clk);
        check("t7_ready", byte_ready, 0);
        byte_valid = 1'b0;
        do_start(6'd1);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h04, 0);
        byte_valid = 1'b0;
        wait_done("t7_done");
        check("t7_mem0", mem[0], 32'h04030201);

        check("stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
